// File: rtl/trace_frame_packer.sv
// Packs WORD_W-bit trace words into WORDS-word frames and hands each one to a CDC flag/ack stage.
// Latency: the last word accepted is followed 2 cycles later by frame_flag, when hold is EMPTY and busy=0.
// Backpressure: none upstream; words that do not fit are dropped and counted (saturating).
//
// Ports:
//   clk, rst         capture clock; synchronous active-high reset
//   din/din_valid    trace word input; flush closes a partial frame
//   frame_out/_len   held frame (word 0 in the low bits) and its valid word count
//   frame_flag       one-cycle strobe into the CDC flag input; xfer_busy is the CDC busy output
//   overflow/_cnt    drop strobe and saturating drop counter
module trace_frame_packer #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 8,
  parameter int CNT_W  = 16,
  localparam int LEN_W = $clog2(WORDS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_W-1:0]       din,
  input  logic                    din_valid,
  input  logic                    flush,
  output logic [WORD_W*WORDS-1:0] frame_out,
  output logic [LEN_W-1:0]        frame_len,
  output logic                    frame_flag,
  input  logic                    xfer_busy,
  output logic                    overflow,
  output logic [CNT_W-1:0]        overflow_cnt
);

  typedef enum logic [1:0] {EMPTY, ARMED, SENT, WAIT} hold_e;

  hold_e                    state_q;
  logic [WORD_W-1:0]        asm_q [WORDS];
  logic [WORD_W-1:0]        asm_d [WORDS];
  logic [LEN_W-1:0]         asm_cnt_q, asm_cnt_d;
  logic                     flush_pend_q, flush_pend_d;
  logic [WORD_W*WORDS-1:0]  frame_q, frame_d;
  logic [LEN_W-1:0]         frame_len_q;
  logic                     frame_flag_q;
  logic                     overflow_q;
  logic [CNT_W-1:0]         overflow_cnt_q;

  logic             full;
  logic             move;
  logic             accept;
  logic             drop;
  logic [LEN_W-1:0] wr_idx;

  always_comb begin
    full   = (asm_cnt_q == LEN_W'(WORDS));
    move   = (full | flush_pend_q) & (state_q == EMPTY);
    // A full assembly can still take a word in the cycle it empties into hold.
    accept = din_valid & (~full | move);
    drop   = din_valid & ~accept;
    wr_idx = move ? '0 : asm_cnt_q;

    asm_d = asm_q;
    for (int i = 0; i < WORDS; i++) begin
      if (accept && (wr_idx == LEN_W'(i))) asm_d[i] = din;
    end
    asm_cnt_d = wr_idx + LEN_W'(accept);

    // On a move the old contents leave; a flush then only sticks if it brought a word of its own.
    if (move) flush_pend_d = flush & accept;
    else      flush_pend_d = flush_pend_q | (flush & ((asm_cnt_q != '0) | accept));

    // Slots at or beyond the count may hold stale words from an earlier frame; mask them.
    frame_d = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (LEN_W'(i) < asm_cnt_q) frame_d[i*WORD_W +: WORD_W] = asm_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      for (int i = 0; i < WORDS; i++) asm_q[i] <= '0;
      asm_cnt_q      <= '0;
      flush_pend_q   <= 1'b0;
      frame_q        <= '0;
      frame_len_q    <= '0;
      frame_flag_q   <= 1'b0;
      overflow_q     <= 1'b0;
      overflow_cnt_q <= '0;
    end else begin
      asm_q        <= asm_d;
      asm_cnt_q    <= asm_cnt_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= drop;
      if (drop && (overflow_cnt_q != '1)) overflow_cnt_q <= overflow_cnt_q + 1'b1;
      frame_flag_q <= 1'b0;

      case (state_q)
        EMPTY: if (move) begin
          frame_q     <= frame_d;
          frame_len_q <= asm_cnt_q;
          state_q     <= ARMED;
        end
        ARMED: if (!xfer_busy) begin
          frame_flag_q <= 1'b1;
          state_q      <= SENT;
        end
        SENT:  if (xfer_busy)  state_q <= WAIT;
        WAIT:  if (!xfer_busy) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign frame_out    = frame_q;
  assign frame_len    = frame_len_q;
  assign frame_flag   = frame_flag_q;
  assign overflow     = overflow_q;
  assign overflow_cnt = overflow_cnt_q;

endmodule

// File: tb/tb_trace_frame_packer.sv
// Directed bench for trace_frame_packer with a simple CDC busy responder.
// Latency: n/a (testbench).
// Backpressure: xfer_busy is driven by the responder or forced high by a test.
module tb_trace_frame_packer;

  logic         clk;
  logic         rst;
  logic [15:0]  din;
  logic         din_valid;
  logic         flush;
  logic [127:0] frame_out;
  logic [3:0]   frame_len;
  logic         frame_flag;
  logic         xfer_busy;
  logic         overflow;
  logic [3:0]   overflow_cnt;

  trace_frame_packer #(.WORD_W(16), .WORDS(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .flush        (flush),
    .frame_out    (frame_out),
    .frame_len    (frame_len),
    .frame_flag   (frame_flag),
    .xfer_busy    (xfer_busy),
    .overflow     (overflow),
    .overflow_cnt (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Observation state updated on every cycle by tick().
  int           cyc = 0;
  int           flags = 0;
  int           flag_cyc = 0;
  int           ovf_seen = 0;
  int           flag_busy_viol = 0;
  logic [127:0] flag_frame = '0;
  logic [3:0]   flag_len = '0;
  // CDC responder: busy rises the cycle after a flag and stays high cdc_hold cycles.
  bit           force_busy = 1'b0;
  int           cdc_hold = 3;
  int           bcnt = 0;
  logic         busy_at_edge;

  task automatic tick();
    busy_at_edge = xfer_busy;
    @(posedge clk);
    #1;
    cyc++;
    if (overflow) ovf_seen++;
    if (frame_flag) begin
      flags++;
      flag_cyc   = cyc;
      flag_frame = frame_out;
      flag_len   = frame_len;
      if (busy_at_edge) flag_busy_viol++;
    end
    if (force_busy) xfer_busy = 1'b1;
    else if (frame_flag) begin
      xfer_busy = 1'b1;
      bcnt = cdc_hold;
    end else if (bcnt > 0) begin
      bcnt--;
      xfer_busy = (bcnt != 0);
    end else xfer_busy = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input logic v, input logic f);
    din = w;
    din_valid = v;
    flush = f;
    tick();
    din_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_flags(input int target, output bit ok);
    for (int i = 0; i < 80 && flags < target; i++) tick();
    ok = (flags >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    compared++; if (frame_out !== 128'h0) begin mismatched++; $display("FAIL reset_frame: got %h want 0", frame_out); end
    compared++; if (frame_len !== 4'd0) begin mismatched++; $display("FAIL reset_len: got %0d want 0", frame_len); end
    compared++; if (frame_flag !== 1'b0) begin mismatched++; $display("FAIL reset_flag: got %b want 0", frame_flag); end
    compared++; if (overflow !== 1'b0 || overflow_cnt !== 4'd0) begin mismatched++; $display("FAIL reset_ovf: got %b/%0d want 0/0", overflow, overflow_cnt); end
  endtask

  task automatic test_full_frame();
    int f0, last;
    bit ok;
    f0 = flags;
    for (int i = 1; i <= 8; i++) send(16'(i), 1'b1, 1'b0);
    last = cyc;
    wait_flags(f0 + 1, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL full_flag_timeout: got %0d flags want %0d", flags - f0, 1); end
    compared++; if (flag_cyc - last !== 2) begin mismatched++; $display("FAIL full_latency: got %0d want 2", flag_cyc - last); end
    compared++; if (flag_frame !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin mismatched++; $display("FAIL full_frame: got %h", flag_frame); end
    compared++; if (flag_len !== 4'd8) begin mismatched++; $display("FAIL full_len: got %0d want 8", flag_len); end
    idle(8);
    compared++; if (flags - f0 !== 1) begin mismatched++; $display("FAIL full_single_flag: got %0d want 1", flags - f0); end
    compared++; if (frame_out !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin mismatched++; $display("FAIL full_hold_stable: got %h", frame_out); end
  endtask

  task automatic test_flush_partial();
    int f0;
    bit ok;
    f0 = flags;
    send(16'h000A, 1'b1, 1'b0);
    send(16'h000B, 1'b1, 1'b0);
    send(16'h000C, 1'b1, 1'b0);
    send(16'h0000, 1'b0, 1'b1);
    wait_flags(f0 + 1, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL flush_timeout: got %0d flags want 1", flags - f0); end
    compared++; if (flag_len !== 4'd3) begin mismatched++; $display("FAIL flush_len: got %0d want 3", flag_len); end
    compared++; if (flag_frame !== 128'h0000_0000_0000_0000_0000_000C_000B_000A) begin mismatched++; $display("FAIL flush_frame: got %h", flag_frame); end
    idle(8);
    compared++; if (flags - f0 !== 1) begin mismatched++; $display("FAIL flush_single_flag: got %0d want 1", flags - f0); end
  endtask

  task automatic test_overflow();
    int f0, o0;
    bit ok;
    f0 = flags;
    o0 = ovf_seen;
    force_busy = 1'b1;
    xfer_busy = 1'b1;
    for (int i = 0; i < 20; i++) send(16'h0100 + 16'(i), 1'b1, 1'b0);
    idle(1);
    compared++; if (overflow_cnt !== 4'd4) begin mismatched++; $display("FAIL ovf_cnt: got %0d want 4", overflow_cnt); end
    compared++; if (ovf_seen - o0 !== 4) begin mismatched++; $display("FAIL ovf_strobes: got %0d want 4", ovf_seen - o0); end
    compared++; if (flags - f0 !== 0) begin mismatched++; $display("FAIL ovf_flag_while_busy: got %0d want 0", flags - f0); end
    compared++; if (frame_out !== 128'h0107_0106_0105_0104_0103_0102_0101_0100) begin mismatched++; $display("FAIL ovf_frame_a_held: got %h", frame_out); end
    force_busy = 1'b0;
    wait_flags(f0 + 1, ok);
    compared++; if (flag_frame !== 128'h0107_0106_0105_0104_0103_0102_0101_0100) begin mismatched++; $display("FAIL ovf_frame_a: got %h", flag_frame); end
    wait_flags(f0 + 2, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL ovf_b_timeout: got %0d flags want 2", flags - f0); end
    compared++; if (flag_frame !== 128'h010F_010E_010D_010C_010B_010A_0109_0108 || flag_len !== 4'd8) begin mismatched++; $display("FAIL ovf_frame_b: got %h len %0d", flag_frame, flag_len); end
    idle(8);
  endtask

  task automatic test_flush_edge();
    int f0;
    bit ok;
    f0 = flags;
    send(16'h0000, 1'b0, 1'b1);
    idle(6);
    compared++; if (flags - f0 !== 0) begin mismatched++; $display("FAIL empty_flush_flag: got %0d want 0", flags - f0); end
    send(16'h0055, 1'b1, 1'b1);
    wait_flags(f0 + 1, ok);
    compared++; if (ok !== 1'b1 || flag_len !== 4'd1) begin mismatched++; $display("FAIL flush_word_len: got %0d want 1", flag_len); end
    compared++; if (flag_frame !== 128'h0055) begin mismatched++; $display("FAIL flush_word_frame: got %h want 55", flag_frame); end
    idle(8);
  endtask

  task automatic test_back_to_back();
    int f0, o0;
    bit ok;
    f0 = flags;
    o0 = ovf_seen;
    for (int i = 0; i < 9; i++) send(16'h0200 + 16'(i), 1'b1, 1'b0);
    wait_flags(f0 + 1, ok);
    compared++; if (flag_frame !== 128'h0207_0206_0205_0204_0203_0202_0201_0200) begin mismatched++; $display("FAIL b2b_frame_a: got %h", flag_frame); end
    idle(8);
    send(16'h0000, 1'b0, 1'b1);
    wait_flags(f0 + 2, ok);
    compared++; if (ok !== 1'b1 || flag_len !== 4'd1 || flag_frame !== 128'h0208) begin mismatched++; $display("FAIL b2b_slot0: got %h len %0d want 0208 len 1", flag_frame, flag_len); end
    compared++; if (ovf_seen - o0 !== 0) begin mismatched++; $display("FAIL b2b_no_drop: got %0d want 0", ovf_seen - o0); end
    idle(8);
  endtask

  task automatic test_saturate();
    int f0, o0;
    bit ok;
    f0 = flags;
    o0 = ovf_seen;
    force_busy = 1'b1;
    xfer_busy = 1'b1;
    for (int i = 0; i < 30; i++) send(16'h0300 + 16'(i), 1'b1, 1'b0);
    idle(1);
    compared++; if (overflow_cnt !== 4'd15) begin mismatched++; $display("FAIL sat_cnt: got %0d want 15", overflow_cnt); end
    compared++; if (ovf_seen - o0 !== 14) begin mismatched++; $display("FAIL sat_strobes: got %0d want 14", ovf_seen - o0); end
    force_busy = 1'b0;
    wait_flags(f0 + 2, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL sat_drain: got %0d flags want 2", flags - f0); end
    idle(8);
  endtask

  task automatic test_reset_in_wait();
    int f0, last;
    bit ok;
    f0 = flags;
    cdc_hold = 20;
    for (int i = 0; i < 13; i++) send(16'h0400 + 16'(i), 1'b1, 1'b0);
    wait_flags(f0 + 1, ok);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bcnt = 0;
    xfer_busy = 1'b0;
    cdc_hold = 3;
    compared++; if (frame_out !== 128'h0 || frame_len !== 4'd0) begin mismatched++; $display("FAIL rst_wait_frame: got %h len %0d want 0", frame_out, frame_len); end
    compared++; if (frame_flag !== 1'b0 || overflow !== 1'b0 || overflow_cnt !== 4'd0) begin mismatched++; $display("FAIL rst_wait_ctl: got %b %b %0d want 0 0 0", frame_flag, overflow, overflow_cnt); end
    f0 = flags;
    idle(3);
    for (int i = 0; i < 8; i++) send(16'h0500 + 16'(i), 1'b1, 1'b0);
    last = cyc;
    wait_flags(f0 + 1, ok);
    compared++; if (ok !== 1'b1 || flag_cyc - last !== 2) begin mismatched++; $display("FAIL rst_new_latency: got %0d want 2", flag_cyc - last); end
    compared++; if (flag_frame !== 128'h0507_0506_0505_0504_0503_0502_0501_0500 || flag_len !== 4'd8) begin mismatched++; $display("FAIL rst_new_frame: got %h len %0d", flag_frame, flag_len); end
    idle(8);
    compared++; if (flag_busy_viol !== 0) begin mismatched++; $display("FAIL flag_while_busy: got %0d want 0", flag_busy_viol); end
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    flush = 1'b0;
    xfer_busy = 1'b0;
    test_reset();
    test_full_frame();
    test_flush_partial();
    test_overflow();
    test_flush_edge();
    test_back_to_back();
    test_saturate();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
